// File: rtl/clb_cfg_pkg.sv
// Shared widths, field offsets and loader state encoding for the CLB configuration path.
package clb_cfg_pkg;

  localparam int CFG_W   = 23;
  localparam int FRAME_W = CFG_W + 1;

  // Config word layout: [22:19] out_sel, [18] lut/ff mux, [17:16] ff_en sel, [15:0] lut
  localparam int OUT_SEL_LSB = 19;
  localparam int MUX_BIT     = 18;
  localparam int FFEN_LSB    = 16;
  localparam int LUT_LSB     = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } ldr_state_t;

endpackage

// File: rtl/cfg_frame_shifter.sv
// Serial-to-parallel frame assembler; frame_o/frame_done_o/parity_ok_o are combinational
// views that include the bit being transferred, so the completed frame is usable on its last edge.
module cfg_frame_shifter
  import clb_cfg_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               shift_i,
  input  logic               bit_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_done_o,
  output logic               parity_ok_o
);

  localparam int BCNT_W = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0] shreg_q;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic               par_q, par_d;

  assign frame_o      = {shreg_q[FRAME_W-2:0], bit_i};
  assign frame_done_o = shift_i && (bit_cnt_q == BCNT_W'(FRAME_W - 1));
  // par_q covers every earlier bit of the frame; folding in bit_i gives the whole-frame XOR
  assign parity_ok_o  = ~(par_q ^ bit_i);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    if (clr_i || frame_done_o) begin
      bit_cnt_d = '0;
      par_d     = 1'b0;
    end else if (shift_i) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      par_d     = par_q ^ bit_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      if (clr_i) begin
        shreg_q <= '0;
      end else if (shift_i) begin
        shreg_q <= frame_o;
      end
    end
  end

endmodule

// File: rtl/clb_config_loader.sv
// Loads NUM_CLB parity-checked 24-bit serial frames into CLBs 0..NUM_CLB-1 via a shared bits bus.
// Last bit at edge N -> wr_en_o high for cycle N+1 only; cfg_ready_o drops until SHIFT resumes at N+2.
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_CLB = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               cfg_valid_i,
  input  logic               cfg_data_i,
  output logic               cfg_ready_o,
  output logic [CFG_W-1:0]   bits_o,
  output logic [NUM_CLB-1:0] wr_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int CNT_W = (NUM_CLB > 1) ? $clog2(NUM_CLB) : 1;

  ldr_state_t         state_q;
  logic [CNT_W-1:0]   clb_idx_q;
  logic [CFG_W-1:0]   bits_q;
  logic [NUM_CLB-1:0] wr_en_q, wr_en_d;
  logic               ready_q, busy_q, done_q, err_q;

  logic               start_go_d;
  logic               shift_en_d;
  logic [FRAME_W-1:0] frame;
  logic               frame_done;
  logic               parity_ok;
  logic               unused_parity_bit;

  // ready_q is set exactly while in SHIFT, so it alone qualifies a transfer
  assign shift_en_d = cfg_valid_i && ready_q;
  assign start_go_d = start_i &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
  assign unused_parity_bit = frame[FRAME_W-1];

  cfg_frame_shifter u_shifter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (start_go_d),
    .shift_i      (shift_en_d),
    .bit_i        (cfg_data_i),
    .frame_o      (frame),
    .frame_done_o (frame_done),
    .parity_ok_o  (parity_ok)
  );

  // One-hot decode; clb_idx_q never exceeds NUM_CLB-1, so no out-of-range enable exists
  always_comb begin
    wr_en_d = '0;
    for (int k = 0; k < NUM_CLB; k++) begin
      wr_en_d[k] = (clb_idx_q == CNT_W'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clb_idx_q <= '0;
      bits_q    <= '0;
      wr_en_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_i) begin
            state_q   <= ST_SHIFT;
            clb_idx_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (frame_done) begin
            ready_q <= 1'b0;
            if (parity_ok) begin
              state_q <= ST_WRITE;
              bits_q  <= frame[CFG_W-1:0];
              wr_en_q <= wr_en_d;
            end else begin
              state_q <= ST_ERROR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          wr_en_q <= '0;
          state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          // bits_q is left untouched here so the CLB latch closes on stable data
          if (clb_idx_q == CNT_W'(NUM_CLB - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            clb_idx_q <= clb_idx_q + 1'b1;
            state_q   <= ST_SHIFT;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o = ready_q;
  assign bits_o      = bits_q;
  assign wr_en_o     = wr_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
